// File: rtl/ram_fifo_ext.sv
// Synchronous FIFO on an inferred dual-port RAM with exact count,
// thresholds, flush, sticky error flags and optional FWFT output.
module ram_dualport_infer #(
  parameter int c_ADDRWIDTH = 9,
  parameter int c_DATAWIDTH = 8
) (
  input  logic                   i_clock,
  input  logic                   i_we,
  input  logic [c_ADDRWIDTH-1:0] i_waddr,
  input  logic [c_DATAWIDTH-1:0] i_wdata,
  input  logic                   i_re,
  input  logic [c_ADDRWIDTH-1:0] i_raddr,
  output logic [c_DATAWIDTH-1:0] o_q
);

  localparam int DEPTH = 1 << c_ADDRWIDTH;

  logic [c_DATAWIDTH-1:0] mem [DEPTH];

  always_ff @(posedge i_clock) begin
    if (i_we) mem[i_waddr] <= i_wdata;
    if (i_re) o_q <= mem[i_raddr];
  end

endmodule

module ram_fifo_ext #(
  parameter int c_ADDRWIDTH = 9,
  parameter int c_DATAWIDTH = 8,
  parameter int c_NEARFULL  = 384,
  parameter int c_NEAREMPTY = 4,
  parameter int c_FWFT      = 0
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic                   i_writeen,
  input  logic [c_DATAWIDTH-1:0] i_data,
  input  logic                   i_readen,
  output logic [c_DATAWIDTH-1:0] o_data,
  output logic                   o_valid,
  output logic [c_ADDRWIDTH:0]   o_count,
  output logic                   o_full,
  output logic                   o_nearfull,
  output logic                   o_empty,
  output logic                   o_nearempty,
  output logic                   o_overflow,
  output logic                   o_underflow,
  input  logic                   i_clearflags
);

  localparam int AW    = c_ADDRWIDTH;
  localparam int DEPTH = 1 << AW;

  localparam logic [AW:0]   FULL_C = (AW+1)'(DEPTH);
  localparam logic [AW:0]   NF_C   = (AW+1)'(c_NEARFULL);
  localparam logic [AW:0]   NE_C   = (AW+1)'(c_NEAREMPTY);
  localparam logic [AW:0]   CONE   = (AW+1)'(1);
  localparam logic [AW-1:0] PONE   = AW'(1);

  logic [AW:0]            count;
  logic [AW:0]            count_nxt;
  logic [AW-1:0]          wptr;
  logic [AW-1:0]          rptr;
  logic                   full;
  logic                   empty_s;
  logic                   valid_s;
  logic                   wr_acc;
  logic                   rd_acc;
  logic                   rd_issue;
  logic                   ovf;
  logic                   udf;
  logic [c_DATAWIDTH-1:0] ram_q;
  logic [c_DATAWIDTH-1:0] data_r;

  assign full   = (count == FULL_C);
  assign wr_acc = i_writeen && !full;
  assign rd_acc = i_readen && !empty_s;

  always_comb begin
    count_nxt = count;
    if (wr_acc && !rd_acc)      count_nxt = count + CONE;
    else if (rd_acc && !wr_acc) count_nxt = count - CONE;
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else if (i_flush) begin
      count <= '0;
      wptr  <= '0;
      rptr  <= '0;
    end else begin
      count <= count_nxt;
      if (wr_acc)   wptr <= wptr + PONE;
      if (rd_issue) rptr <= rptr + PONE;
      // a fresh error wins over a same-cycle clear
      if (i_writeen && full) ovf <= 1'b1;
      else if (i_clearflags) ovf <= 1'b0;
      if (i_readen && empty_s) udf <= 1'b1;
      else if (i_clearflags)   udf <= 1'b0;
    end
  end

  ram_dualport_infer #(
    .c_ADDRWIDTH(AW),
    .c_DATAWIDTH(c_DATAWIDTH)
  ) u_ram (
    .i_clock(i_clock),
    .i_we   (wr_acc && !i_reset && !i_flush),
    .i_waddr(wptr),
    .i_wdata(i_data),
    .i_re   (rd_issue && !i_reset && !i_flush),
    .i_raddr(rptr),
    .o_q    (ram_q)
  );

  generate
    if (c_FWFT != 0) begin : g_fwft
      logic          hv;
      logic          qv;
      logic          take;
      logic [AW:0]   mcnt;

      // words still sitting in RAM, not yet in ram_q or the holding reg
      assign mcnt     = count - {{AW{1'b0}}, hv} - {{AW{1'b0}}, qv};
      assign take     = qv && (!hv || rd_acc);
      assign rd_issue = (mcnt != '0) && (!qv || take);
      assign empty_s  = !hv;
      assign valid_s  = hv;

      always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
          hv     <= 1'b0;
          qv     <= 1'b0;
          data_r <= '0;
        end else begin
          qv <= rd_issue || (qv && !take);
          if (take) begin
            hv     <= 1'b1;
            data_r <= ram_q;
          end else if (rd_acc) begin
            hv <= 1'b0;
          end
        end
      end
    end else begin : g_std
      logic rd_d1;
      logic vld;

      assign rd_issue = rd_acc;
      assign empty_s  = (count == '0);
      assign valid_s  = vld;

      always_ff @(posedge i_clock) begin
        if (i_reset || i_flush) begin
          rd_d1  <= 1'b0;
          vld    <= 1'b0;
          data_r <= '0;
        end else begin
          rd_d1 <= rd_acc;
          vld   <= rd_d1;
          if (rd_d1) data_r <= ram_q;
        end
      end
    end
  endgenerate

  assign o_data      = data_r;
  assign o_valid     = valid_s;
  assign o_count     = count;
  assign o_full      = full;
  assign o_nearfull  = (count >= NF_C);
  assign o_empty     = empty_s;
  assign o_nearempty = (count <= NE_C);
  assign o_overflow  = ovf;
  assign o_underflow = udf;

endmodule

// File: tb/tb_ram_fifo_ext.sv
// Directed bench for ram_fifo_ext: one standard-mode and one
// FWFT-mode instance, depth 16, thresholds 12/2.
module tb_ram_fifo_ext;

  logic       clk;
  int         n_cmp;
  int         n_bad;

  logic       s_rst, s_fl, s_we, s_re, s_clr;
  logic [7:0] s_din;
  logic [7:0] s_dout;
  logic [4:0] s_cnt;
  logic       s_vld, s_full, s_nf, s_emp, s_ne, s_ovf, s_udf;

  logic       f_rst, f_fl, f_we, f_re, f_clr;
  logic [7:0] f_din;
  logic [7:0] f_dout;
  logic [4:0] f_cnt;
  logic       f_vld, f_full, f_nf, f_emp, f_ne, f_ovf, f_udf;

  ram_fifo_ext #(
    .c_ADDRWIDTH(4), .c_DATAWIDTH(8),
    .c_NEARFULL(12), .c_NEAREMPTY(2), .c_FWFT(0)
  ) dut_s (
    .i_clock(clk), .i_reset(s_rst), .i_flush(s_fl),
    .i_writeen(s_we), .i_data(s_din), .i_readen(s_re),
    .o_data(s_dout), .o_valid(s_vld), .o_count(s_cnt),
    .o_full(s_full), .o_nearfull(s_nf), .o_empty(s_emp),
    .o_nearempty(s_ne), .o_overflow(s_ovf),
    .o_underflow(s_udf), .i_clearflags(s_clr)
  );

  ram_fifo_ext #(
    .c_ADDRWIDTH(4), .c_DATAWIDTH(8),
    .c_NEARFULL(12), .c_NEAREMPTY(2), .c_FWFT(1)
  ) dut_f (
    .i_clock(clk), .i_reset(f_rst), .i_flush(f_fl),
    .i_writeen(f_we), .i_data(f_din), .i_readen(f_re),
    .o_data(f_dout), .o_valid(f_vld), .o_count(f_cnt),
    .o_full(f_full), .o_nearfull(f_nf), .o_empty(f_emp),
    .o_nearempty(f_ne), .o_overflow(f_ovf),
    .o_underflow(f_udf), .i_clearflags(f_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    {s_rst, s_fl, s_we, s_re, s_clr} = 5'b10000;
    {f_rst, f_fl, f_we, f_re, f_clr} = 5'b10000;
    s_din = 8'h00;
    f_din = 8'h00;

    // reset values
    tick();
    s_rst = 0;
    f_rst = 0;
    chk("rst_cnt",  32'(s_cnt),  0);
    chk("rst_emp",  32'(s_emp),  1);
    chk("rst_full", 32'(s_full), 0);
    chk("rst_nf",   32'(s_nf),   0);
    chk("rst_ne",   32'(s_ne),   1);
    chk("rst_vld",  32'(s_vld),  0);
    chk("rst_dat",  32'(s_dout), 0);
    chk("rst_ovf",  32'(s_ovf),  0);
    chk("rst_udf",  32'(s_udf),  0);

    // underflow on empty read, then clear
    s_re = 1;
    tick();
    s_re = 0;
    chk("udf_set", 32'(s_udf), 1);
    chk("udf_cnt", 32'(s_cnt), 0);
    chk("udf_vld", 32'(s_vld), 0);
    tick();
    chk("udf_vld2", 32'(s_vld), 0);
    s_clr = 1;
    tick();
    s_clr = 0;
    chk("udf_clr", 32'(s_udf), 0);

    // fill 0x00..0x0F, watching thresholds
    for (int i = 0; i < 16; i++) begin
      s_we = 1;
      s_din = 8'(i);
      tick();
      chk("fill_cnt",  32'(s_cnt),  32'(i + 1));
      chk("fill_ne",   32'(s_ne),   32'((i + 1) <= 2));
      chk("fill_nf",   32'(s_nf),   32'((i + 1) >= 12));
      chk("fill_full", 32'(s_full), 32'((i + 1) == 16));
    end
    s_din = 8'hAA;
    tick();
    s_we = 0;
    chk("ovf_set", 32'(s_ovf), 1);
    chk("ovf_cnt", 32'(s_cnt), 16);

    // drain, one word per cycle, data two edges after request
    for (int k = 0; k < 18; k++) begin
      s_re = (k < 16);
      tick();
      if (k >= 1 && k <= 16) begin
        chk("rd_vld", 32'(s_vld),  1);
        chk("rd_dat", 32'(s_dout), 32'(k - 1));
      end
      if (k == 15) chk("rd_emp", 32'(s_emp), 1);
      if (k == 17) begin
        chk("rd_vld0", 32'(s_vld),  0);
        chk("rd_hold", 32'(s_dout), 32'h0F);
      end
    end
    chk("rd_udf", 32'(s_udf), 0);

    // pointer wrap with 8 resident words
    for (int i = 0; i < 8; i++) begin
      s_we = 1;
      s_din = 8'(8'h20 + i);
      tick();
    end
    for (int j = 0; j < 40; j++) begin
      s_we = 1;
      s_re = 1;
      s_din = 8'(8'h28 + j);
      tick();
      chk("wrap_cnt", 32'(s_cnt), 8);
      if (j >= 1) chk("wrap_dat", 32'(s_dout), 32'(8'h20 + j - 1));
    end
    s_we = 0;
    s_re = 0;
    tick();
    chk("wrap_last", 32'(s_dout), 32'h47);

    // flush at count 10 keeps the overflow flag
    s_we = 1;
    s_din = 8'h50;
    tick();
    s_din = 8'h51;
    tick();
    chk("fl_pre", 32'(s_cnt), 10);
    s_fl = 1;
    s_re = 1;
    tick();
    s_fl = 0;
    s_we = 0;
    s_re = 0;
    chk("fl_cnt", 32'(s_cnt), 0);
    chk("fl_emp", 32'(s_emp), 1);
    chk("fl_ovf", 32'(s_ovf), 1);
    chk("fl_udf", 32'(s_udf), 0);
    chk("fl_dat", 32'(s_dout), 0);
    s_we = 1;
    s_din = 8'h77;
    tick();
    s_we = 0;
    s_re = 1;
    tick();
    s_re = 0;
    tick();
    chk("fl_rt_vld", 32'(s_vld),  1);
    chk("fl_rt_dat", 32'(s_dout), 32'h77);
    chk("fl_rt_cnt", 32'(s_cnt),  0);

    // reset mid-stream with a read in flight
    for (int i = 0; i < 8; i++) begin
      s_we = 1;
      s_din = 8'(8'h60 + i);
      tick();
    end
    s_we = 0;
    s_re = 1;
    tick();
    chk("mr_cnt7", 32'(s_cnt), 7);
    s_re = 0;
    s_rst = 1;
    tick();
    s_rst = 0;
    chk("mr_cnt", 32'(s_cnt),  0);
    chk("mr_emp", 32'(s_emp),  1);
    chk("mr_vld", 32'(s_vld),  0);
    chk("mr_dat", 32'(s_dout), 0);
    chk("mr_ovf", 32'(s_ovf),  0);
    chk("mr_ne",  32'(s_ne),   1);
    tick();
    chk("mr_vld2", 32'(s_vld), 0);

    // FWFT: single word falls through after two edges
    chk("fw_rst_emp", 32'(f_emp), 1);
    f_we = 1;
    f_din = 8'h5A;
    tick();
    f_we = 0;
    chk("fw_n0_emp", 32'(f_emp), 1);
    chk("fw_n0_cnt", 32'(f_cnt), 1);
    tick();
    chk("fw_n1_emp", 32'(f_emp), 1);
    tick();
    chk("fw_n2_emp", 32'(f_emp),  0);
    chk("fw_n2_vld", 32'(f_vld),  1);
    chk("fw_n2_dat", 32'(f_dout), 32'h5A);
    f_re = 1;
    tick();
    f_re = 0;
    chk("fw_pop_emp", 32'(f_emp), 1);
    chk("fw_pop_cnt", 32'(f_cnt), 0);
    chk("fw_pop_udf", 32'(f_udf), 0);

    // FWFT sustained pops
    for (int i = 0; i < 4; i++) begin
      f_we = 1;
      f_din = 8'(8'h10 + i);
      tick();
    end
    f_we = 0;
    tick();
    tick();
    chk("fw_s_cnt", 32'(f_cnt),  4);
    chk("fw_s_dat", 32'(f_dout), 32'h10);
    for (int k = 0; k < 4; k++) begin
      f_re = 1;
      tick();
      if (k < 3) chk("fw_s_pop", 32'(f_dout), 32'(8'h11 + k));
      else       chk("fw_s_emp", 32'(f_emp), 1);
    end
    tick();
    f_re = 0;
    chk("fw_udf", 32'(f_udf), 1);
    chk("fw_cnt", 32'(f_cnt), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ram_fifo_ext.md
Name: ram_fifo_ext

Overview:
Next-generation synchronous FIFO built on the dual-port EBR RAM inferrer (ram_dualport_infer). Generalises the existing byte FIFO with the following additions:
- full 2^c_ADDRWIDTH capacity
- exact occupancy count
- programmable near-full/near-empty thresholds
- selectable standard or first-word-fall-through (FWFT) read mode
- synchronous flush
- sticky overflow/underflow error flags

Used as the buffering stage between the UART and D-Bus link engines.

Parameters:
- c_ADDRWIDTH, 9: RAM address width; DEPTH = 2^c_ADDRWIDTH entries (minimum 2).
- c_DATAWIDTH, 8: word width.
- c_NEARFULL, 384: o_nearfull asserts when count >= this value (1..DEPTH).
- c_NEAREMPTY, 4: o_nearempty asserts when count <= this value (0..DEPTH-1).
- c_FWFT, 0: 0 = standard read (data one cycle after read); 1 = first-word-fall-through.

Ports:
- i_clock  in  1  sole clock, rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous flush; empties FIFO, keeps error flags.
- i_writeen  in  1  write request.
- i_data  in  c_DATAWIDTH  write data.
- i_readen  in  1  read request (standard) / pop (FWFT).
- o_data  out  c_DATAWIDTH  read data.
- o_valid  out  1  standard: o_data valid this cycle; FWFT: equals !o_empty.
- o_count  out  c_ADDRWIDTH+1  words stored, 0..DEPTH.
- o_full  out  1  count == DEPTH.
- o_nearfull  out  1  count >= c_NEARFULL.
- o_empty  out  1  no word readable.
- o_nearempty  out  1  count <= c_NEAREMPTY.
- o_overflow  out  1  sticky: write attempted while full.
- o_underflow  out  1  sticky: read attempted while empty.
- i_clearflags  in  1  clears o_overflow/o_underflow.

Behaviour:
- Reset (i_reset high at an edge) sets pointers=0, count=0, o_empty=1, o_full=0, o_nearfull=0, o_nearempty=1, o_valid=0, o_data=0, o_overflow=0, o_underflow=0. Reset overrides all other inputs.
- Write acceptance: i_writeen && !o_full. A write while full is dropped and sets o_overflow. This holds even when a read is accepted in the same cycle; there is no write-through when full.
- Read acceptance: i_readen && !o_empty. A read while empty sets o_underflow and changes no state.
- Count arithmetic: count +1 on accepted write only, -1 on accepted read only, unchanged on both or neither. All status outputs derive from the registered count/pointers; they are valid the cycle after the causing edge.
- Pointers: c_ADDRWIDTH bits, wrap modulo DEPTH. Full versus empty is distinguished by count, never by pointer equality. RAM read and write addresses never collide, because writes go to free slots and reads come from occupied slots.
- Standard mode (c_FWFT=0):
  - o_empty = (count==0).
  - Accepted read at edge N: o_data and o_valid=1 present the head word after edge N+1; o_valid is a one-cycle pulse per read.
  - Back-to-back reads give one word per cycle.
  - o_data holds its last value when o_valid=0.
- FWFT mode (c_FWFT=1):
  - An output holding register plus prefetch logic presents the head word with o_valid=1 and o_empty=0 without a read request.
  - i_readen pops the head word; the next word appears after the following edge, giving a sustained one word per cycle.
  - A write into an empty FIFO at edge N clears o_empty after edge N+2 (RAM read latency plus output register).
  - count includes the word in the holding register. Capacity stays DEPTH.
- Flush (i_flush high, i_reset low): same state effect as reset, except o_overflow/o_underflow are kept. Write and read in the flush cycle are ignored and raise no errors.
- Sticky flags: set condition takes priority over i_clearflags in the same cycle.
- Thresholds compare on the unsigned (c_ADDRWIDTH+1)-bit count.

Test Plan:
All scenarios use c_ADDRWIDTH=4 (DEPTH 16), c_NEARFULL=12, c_NEAREMPTY=2.
- Reset then 16 writes 0x00..0x0F:
  - o_nearempty falls when count reaches 3.
  - o_nearfull rises when count reaches 12.
  - o_full=1 when count reaches 16.
  - 17th write 0xAA dropped, o_overflow=1.
  - 16 reads return 0x00..0x0F in order, then o_empty=1.
- Standard mode: read on empty FIFO -> o_underflow=1, count stays 0, o_valid stays 0; i_clearflags clears o_underflow the next cycle.
- Pointer wrap: 40 cycles of simultaneous write/read with 8 words resident -> count constant at 8, data order preserved across wrap.
- FWFT: single write 0x5A at edge N -> o_empty=0 and o_data=0x5A after edge N+2; pop -> o_empty=1 and count=0.
- Flush at count=10 with o_overflow=1 -> count=0, o_empty=1, o_overflow still 1; next write/read round-trips correctly.
- Reset asserted mid-stream (count=7, read in flight) -> all outputs reach reset values next cycle, with no o_valid pulse from the in-flight read.
